// File: rtl/rq_arbiter.sv
// Round-robin requester arbiter with bounded grant slots, lockout after a
// timeout, and a fixed idle guard between grants.
module rq_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SLOT_MAX = 64,
  parameter int GAP_LEN  = 2
) (
  input  logic                     clk80MHz,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         rq,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(SLOT_MAX);
  localparam int GW  = 4;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} st_t;

  st_t              st;
  logic [N_REQ-1:0] s1, rq_s, lock, elig, set_lock;
  logic [IDW-1:0]   last_id, win, idxw;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             found, to_fire;

  // Lock is set on timeout and survives until the synchronized request is seen low.
  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      s1   <= '0;
      rq_s <= '0;
      lock <= '0;
    end else begin
      s1   <= rq;
      rq_s <= s1;
      lock <= set_lock | (lock & rq_s);
    end
  end

  assign elig     = rq_s & ~lock;
  assign to_fire  = (st == S_GRANT) && rq_s[gnt_id] && (cnt == CW'(SLOT_MAX-1));
  assign set_lock = to_fire ? gnt : '0;

  always_comb begin
    win   = last_id;
    found = 1'b0;
    idxw  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idxw = IDW'((int'(last_id) + k) % N_REQ);
      if (!found && elig[idxw]) begin
        win   = idxw;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      st      <= S_IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      gcnt    <= '0;
      last_id <= IDW'(N_REQ-1);
    end else begin
      timeout <= 1'b0;
      case (st)
        S_IDLE: begin
          if (found) begin
            st      <= S_GRANT;
            gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gnt_id  <= win;
            last_id <= win;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        S_GRANT: begin
          // A release seen together with the slot limit counts as a normal release.
          if (!rq_s[gnt_id]) begin
            st   <= S_GAP;
            gnt  <= '0;
            gcnt <= '0;
          end else if (to_fire) begin
            st      <= S_GAP;
            gnt     <= '0;
            gcnt    <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP_LEN-1)) begin
            st   <= S_IDLE;
            busy <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rq_arbiter.sv
// Bench for rq_arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model.
module tb_rq_arbiter;
  localparam int N = 4, SLOT = 64, GAP = 2;

  logic         clk80MHz = 1'b0;
  logic         rst;
  logic [N-1:0] rq;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy, timeout;

  int total = 0, bad = 0;

  rq_arbiter #(.N_REQ(N), .SLOT_MAX(SLOT), .GAP_LEN(GAP)) dut (
    .clk80MHz(clk80MHz), .rst(rst), .rq(rq), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk80MHz = ~clk80MHz;

  // Reference model: owner/grant start/gap end kept as edge timestamps.
  int           n = 0, own = -1, gstart = 0, gap_end = -100, last = N-1;
  logic [N-1:0] lock = '0, h1 = '0, h2 = '0, m_gnt = '0;
  logic [1:0]   m_id = '0;
  logic         m_busy = 1'b0, m_to = 1'b0;

  task automatic model_edge();
    logic [N-1:0] sees, elig;
    int w;
    n++;
    sees = h2; h2 = h1; h1 = rq;
    m_to = 1'b0;
    if (rst) begin
      own = -1; gap_end = n; lock = '0; last = N-1; m_id = '0; h1 = '0; h2 = '0;
    end else begin
      elig = sees & ~lock;
      lock = lock & sees;
      if (own >= 0) begin
        if (!sees[own]) begin
          own = -1; gap_end = n + GAP;
        end else if (n - gstart == SLOT) begin
          lock[own] = 1'b1; m_to = 1'b1; own = -1; gap_end = n + GAP;
        end
      end else if (n > gap_end && elig != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          int idx = (last + k) % N;
          if (w < 0 && elig[idx]) w = idx;
        end
        own = w; last = w; m_id = 2'(w); gstart = n;
      end
    end
    m_gnt = '0;
    if (own >= 0) m_gnt[own] = 1'b1;
    m_busy = (own >= 0) || (n < gap_end);
  endtask

  task automatic cyc();
    @(posedge clk80MHz);
    model_edge();
    @(negedge clk80MHz);
  endtask

  task automatic do_reset();
    rst = 1'b1; rq = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rq = '1;
    cyc(); cyc();
    total++;
    if (gnt !== '0 || gnt_id !== '0 || busy !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL reset_state got gnt=%b id=%0d busy=%b to=%b exp all zero", gnt, gnt_id, busy, timeout);
    end
    rst = 1'b0; rq = '0;
    for (int k = 0; k < 3; k++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL reset_idle got %b/%0d/%b/%b exp %b/%0d/%b/%b", gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
    end
  endtask

  task automatic test_single();
    int kg = -1, kd = -1, kb = -1;
    rq = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL single_model k=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", k, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      if (kg < 0 && gnt != '0) kg = k;
    end
    total++;
    if (kg !== 2 || gnt_id !== 2'd2) begin
      bad++; $display("FAIL single_latency got edge=%0d id=%0d exp edge=2 id=2", kg, gnt_id);
    end
    rq = '0;
    for (int k = 0; k < 10; k++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL single_release k=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", k, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      if (kd < 0 && gnt == '0) kd = k;
      if (kb < 0 && !busy) kb = k;
    end
    total++;
    if (kd !== 2 || kb !== 4) begin
      bad++; $display("FAIL single_drop got gnt_drop=%0d busy_drop=%0d exp 2 and 4", kd, kb);
    end
  endtask

  task automatic test_round_robin();
    int order[$], widths[$];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int gcyc = -100, gid = 0, w = 0;
    logic [N-1:0] pg = '0;
    do_reset();
    rq = 4'hF;
    for (int c = 0; c < 80; c++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL rr_model c=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", c, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      if (gnt != '0 && pg == '0) begin
        gid = int'(gnt_id); order.push_back(gid); gcyc = c; w = 1;
      end else if (gnt != '0) w++;
      if (gnt == '0 && pg != '0) widths.push_back(w);
      pg = gnt;
      if (c == gcyc + 4) rq[gid] = 1'b0;
      if (c == gcyc + 5) rq[gid] = 1'b1;
    end
    total++;
    if (order.size() < 5 || widths.size() < 4) begin
      bad++; $display("FAIL rr_count got grants=%0d widths=%0d exp >=5 and >=4", order.size(), widths.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (order[i] !== exp_ord[i]) begin
          bad++; $display("FAIL rr_order i=%0d got %0d exp %0d", i, order[i], exp_ord[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (widths[i] !== 7) begin
          bad++; $display("FAIL rr_width i=%0d got %0d exp 7", i, widths[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int hi = 0, tos = 0, ng = 0;
    logic got = 1'b0;
    logic [N-1:0] pg = '0;
    do_reset();
    rq = 4'b0001;
    for (int c = 0; c < 200; c++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL to_model c=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", c, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      hi += int'(gnt[0]); tos += int'(timeout);
      if (gnt != '0 && pg == '0) ng++;
      pg = gnt;
    end
    total++;
    if (hi !== SLOT || tos !== 1 || ng !== 1) begin
      bad++; $display("FAIL to_held got width=%0d pulses=%0d grants=%0d exp %0d 1 1", hi, tos, ng, SLOT);
    end
    rq = '0;
    cyc(); cyc();
    rq = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (gnt[0]) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL to_unlock got no regrant exp regrant to 0");
    end
  endtask

  task automatic test_competitor();
    int order[$], rise[$], fall[$];
    int tos = 0;
    logic [N-1:0] pg = '0;
    do_reset();
    rq = 4'b0011;
    for (int c = 0; c < 220; c++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL comp_model c=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", c, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      tos += int'(timeout);
      if (gnt != '0 && pg == '0) begin order.push_back(int'(gnt_id)); rise.push_back(c); end
      if (gnt == '0 && pg != '0) fall.push_back(c);
      pg = gnt;
    end
    total++;
    if (order.size() != 2 || fall.size() < 1 || tos !== 2) begin
      bad++; $display("FAIL comp_count got grants=%0d falls=%0d pulses=%0d exp 2 >=1 2", order.size(), fall.size(), tos);
    end else begin
      total++;
      if (order[0] !== 0 || order[1] !== 1 || fall[0] - rise[0] !== SLOT || rise[1] - fall[0] !== GAP + 1) begin
        bad++; $display("FAIL comp_seq got ids=%0d,%0d width=%0d idle=%0d exp 0,1 %0d %0d", order[0], order[1], fall[0]-rise[0], rise[1]-fall[0], SLOT, GAP+1);
      end
    end
  endtask

  task automatic test_simul_release();
    int hi = 0, tos = 0;
    logic got = 1'b0;
    do_reset();
    rq = 4'b0001;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc();
      if (gnt[0]) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL simul_grant got none exp grant to 0");
    end
    hi = 1;
    for (int c = 0; c < 66; c++) begin
      if (c == 61) rq = '0;
      if (c == 63) rq = 4'b0001;
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL simul_model c=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", c, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      hi += int'(gnt[0]); tos += int'(timeout);
    end
    total++;
    if (hi !== SLOT || tos !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL simul_release got width=%0d pulses=%0d busy=%b exp %0d 0 0", hi, tos, busy, SLOT);
    end
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (gnt[0]) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL simul_nolock got no regrant exp regrant to 0");
    end
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    do_reset();
    rq = 4'b1010;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc();
      if (gnt != '0) got = 1'b1;
    end
    total++;
    if (!got || gnt_id !== 2'd1) begin
      bad++; $display("FAIL rstmid_first got id=%0d granted=%b exp id=1", gnt_id, got);
    end
    for (int c = 0; c < SLOT - 1; c++) cyc();
    rst = 1'b1;
    cyc();
    total++;
    if (gnt !== '0 || timeout !== 1'b0 || busy !== 1'b0 || gnt_id !== '0) begin
      bad++; $display("FAIL rstmid_edge got gnt=%b to=%b busy=%b id=%0d exp 0 0 0 0", gnt, timeout, busy, gnt_id);
    end
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL rstmid_model c=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b", c, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      if (gnt != '0) got = 1'b1;
    end
    total++;
    if (!got || gnt_id !== 2'd1) begin
      bad++; $display("FAIL rstmid_next got id=%0d granted=%b exp id=1", gnt_id, got);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      cyc(); total++;
      if ({gnt, gnt_id, busy, timeout} !== {m_gnt, m_id, m_busy, m_to}) begin
        bad++; $display("FAIL rand_model i=%0d rq=%b got %b/%0d/%b/%b exp %b/%0d/%b/%b", i, rq, gnt, gnt_id, busy, timeout, m_gnt, m_id, m_busy, m_to);
      end
      total++;
      if ($countones(gnt) > 1) begin
        bad++; $display("FAIL rand_onehot i=%0d got gnt=%b exp at most one bit", i, gnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rq = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_competitor();
    test_simul_release();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rq_arbiter.md
RQ_ARBITER -- requirements
Module: rq_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: SLOT_MAX, 64, maximum grant length in clk80MHz cycles (2..255).
REQ-003 Parameter: GAP_LEN, 2, idle guard cycles after every grant release (1..15).
REQ-004 Port: clk80MHz  in  1  sole clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 Port: rq  in  N_REQ  per-requester level request (asynchronous to clk80MHz).
REQ-007 Port: gnt  out  N_REQ  one-hot grant, registered.
REQ-008 Port: gnt_id  out  clog2(N_REQ)  index of current or last granted requester.
REQ-009 Port: busy  out  1  high in GRANT and GAP states.
REQ-010 Port: timeout  out  1  one-cycle pulse when a grant is revoked at SLOT_MAX.

Function
REQ-011 Each rq bit SHALL pass a 2-flop synchronizer; arbitration uses only the second stage (rq_s).
REQ-012 FSM states SHALL be IDLE, GRANT, GAP; encoding free.
REQ-013 IDLE: gnt=0; if any eligible rq_s bit set, next edge SHALL enter GRANT, set gnt one-hot to the winner, load gnt_id, clear slot counter.
REQ-014 Winner SHALL be round-robin: first eligible index searching upward from last_id+1, wrapping modulo N_REQ.
REQ-015 last_id SHALL update to the winner on entry to GRANT.
REQ-016 Latency: rq bit first sampled high at edge E0 SHALL produce gnt at edge E2 when arbiter is IDLE (no eligible competitors with higher RR priority).
REQ-017 GRANT: slot counter increments once per cycle; gnt held constant.
REQ-018 GRANT: if rq_s[gnt_id]==0, next edge SHALL clear gnt and enter GAP (normal release).
REQ-019 GRANT: if counter reaches SLOT_MAX-1 with rq_s[gnt_id] still 1, next edge SHALL clear gnt, pulse timeout for exactly one cycle, enter GAP; gnt therefore high exactly SLOT_MAX cycles.
REQ-020 Release and timeout condition in the same cycle SHALL be treated as normal release; no timeout pulse.
REQ-021 A timed-out requester SHALL be locked out (ineligible) until its rq_s is observed low for at least one cycle; lockout flag per requester.
REQ-022 GAP: gnt=0 for exactly GAP_LEN cycles, then IDLE; requests arriving during GAP are held, not lost (level semantics).
REQ-023 gnt SHALL never have more than one bit set; gnt SHALL be zero in IDLE and GAP.
REQ-024 Requests changing in the cycle of arbitration SHALL be resolved on rq_s values at that edge only.
REQ-025 gnt_id SHALL retain its value outside GRANT.

Reset
REQ-026 On rst=1 at a rising edge: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, slot/gap counters=0, lockout flags=0, synchronizer flops=0, last_id=N_REQ-1 (so index 0 has first priority).
REQ-027 rst asserted mid-grant SHALL drop gnt on that same edge with no timeout pulse; behaviour thereafter identical to power-up.

Verification
REQ-028 Single request: rq=4'b0100 from E0, held 10 cycles -> gnt=4'b0100 at E2, gnt_id=2, gnt drops 2 cycles after rq falls, busy low after GAP_LEN=2 further cycles.
REQ-029 Round robin: rq=4'b1111 held, SLOT_MAX=64, each requester drops rq 5 cycles after grant and re-raises next cycle -> grant order 0,1,2,3,0; gnt width 7 cycles each.
REQ-030 Timeout: rq=4'b0001 held 200 cycles, SLOT_MAX=64 -> gnt[0] high exactly 64 cycles, timeout one-cycle pulse, no regrant to 0 until rq[0] low ≥1 cycle.
REQ-031 Timeout with competitor: rq=4'b0011 held, requester 0 times out -> requester 1 granted after GAP; requester 0 remains locked out while held.
REQ-032 Simultaneous release/timeout: rq[gnt_id] falls at sampling edge of cycle SLOT_MAX -> no timeout pulse, GAP entered.
REQ-033 Reset mid-grant: rst=1 for one edge during GRANT -> gnt=0, timeout=0 that edge; with rq=4'b1010 held, next grant goes to requester 1.
